// File: rtl/wbm_pkg.sv
// Shared definitions for the Wishbone command sequencer.
//   state_e  : sequencer FSM states
//   cmd_t    : one queued command {we, adr, dat, sel}, CMD_W bits when packed
//   ERR_DAT  : read data returned for writes and aborted cycles
package wbm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CMD_W = 1 + ADR_W + DAT_W + SEL_W;

    localparam logic [DAT_W-1:0] ERR_DAT = 32'h0;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } cmd_t;

endpackage

// File: rtl/wbm_cmd_fifo.sv
// Synchronous command queue, first-word-fall-through read port.
//   clk_i/rst_ni : clock, async active-low reset (flushes pointers and count)
//   push_i/wdata_i : write strobe and data, ignored when full
//   pop_i/rdata_o  : read strobe and head entry, pop ignored when empty
//   full_o/empty_o : occupancy flags
module wbm_cmd_fifo
    import wbm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [CMD_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [CMD_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: queued commands become single read/write cycles,
// one response (data + abort flag) returned per command, in order.
//   wb_clk_i/wb_rst_ni           : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o, cmd_* : command stream into the queue
//   rsp_valid_o/rsp_ready_i, rsp_* : response stream (rsp_err_o = watchdog abort)
//   wbm_*                        : Wishbone master bus
//   busy_o                       : queue non-empty or a transfer in progress
// TIMEOUT = stb cycles without ack before abort; 0 disables the watchdog.
module wb_master_seq
    import wbm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [DAT_W-1:0] wbm_dat_i,
    output logic             busy_o
);

    localparam int             WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    cmd_t             cmd_in, head, cmd_q, cmd_d;
    logic [CMD_W-1:0] head_raw;
    logic             fifo_full, fifo_empty, pop;
    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             timeout_hit;

    assign cmd_in = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
    assign head   = cmd_t'(head_raw);

    wbm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (rst_n),
        .push_i  (cmd_valid_i),
        .wdata_i (cmd_in),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            cyc_q     <= 1'b0;
            wd_q      <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cyc_q     <= cyc_d;
            wd_q      <= wd_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cyc_d     = cyc_q;
        wd_d      = wd_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = head;
                    cyc_d   = 1'b1;
                    wd_d    = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ack takes priority over a simultaneous watchdog expiry.
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    wd_d      = '0;
                    rsp_dat_d = cmd_q.we ? ERR_DAT : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timeout_hit) begin
                    cyc_d     = 1'b0;
                    wd_d      = '0;
                    rsp_dat_d = ERR_DAT;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = ~fifo_full;
        wbm_cyc_o   = cyc_q;
        wbm_stb_o   = cyc_q;
        wbm_we_o    = cmd_q.we;
        wbm_sel_o   = cmd_q.sel;
        wbm_adr_o   = cmd_q.adr;
        wbm_dat_o   = cmd_q.dat;
        rsp_valid_o = (state_q == S_RESP);
        rsp_dat_o   = rsp_dat_q;
        rsp_err_o   = rsp_err_q;
        busy_o      = ~fifo_empty | (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_wb_master_seq.sv
module tb_wb_master_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we, ack, busy;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;

    int checks = 0;
    int errors = 0;

    wb_master_seq #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (rdat),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_stb();
        int n = 0;
        while (stb !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("stb_seen", {31'd0, stb}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b1; ack = 1'b0; rdat = '0;
        tick(); tick();
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_adr", adr, 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick();

        // 1: write, slave acks in the second stb cycle
        push(1'b1, 32'h3800_0010, 32'hA5A5_1234, 4'hF);
        chk("t1_stb_latency", {31'd0, stb}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_stb", {31'd0, stb}, 32'd1);
        chk("t1_cyc", {31'd0, cyc}, 32'd1);
        chk("t1_we", {31'd0, we}, 32'd1);
        chk("t1_adr", adr, 32'h3800_0010);
        chk("t1_dat", wdat, 32'hA5A5_1234);
        chk("t1_sel", {28'd0, sel}, 32'hF);
        tick();
        chk("t1_stb_hold", {31'd0, stb}, 32'd1);
        chk("t1_adr_hold", adr, 32'h3800_0010);
        chk("t1_dat_hold", wdat, 32'hA5A5_1234);
        ack = 1'b1; rdat = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; rdat = '0;
        chk("t1_cyc_drop", {31'd0, cyc}, 32'd0);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_dat", rsp_dat, 32'h0);
        chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
        tick();
        chk("t1_rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // 2: read with ack in the first stb cycle
        push(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        tick();
        chk("t2_stb", {31'd0, stb}, 32'd1);
        chk("t2_we", {31'd0, we}, 32'd0);
        chk("t2_adr", adr, 32'h3000_0004);
        ack = 1'b1; rdat = 32'hCAFE_F00D;
        tick();
        ack = 1'b0; rdat = '0;
        chk("t2_cyc_drop", {31'd0, cyc}, 32'd0);
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_dat", rsp_dat, 32'hCAFE_F00D);
        chk("t2_rsp_err", {31'd0, rsp_err}, 32'd0);
        tick();

        // 5a + 3: response held pending while the queue fills
        rsp_ready = 1'b0;
        push(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        wait_stb();
        ack = 1'b1; rdat = 32'h1234_5678;
        tick();
        ack = 1'b0; rdat = '0;
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t5_rsp_dat", rsp_dat, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            chk("t3_ready_before_push", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0100 + 32'(4 * i);
            cmd_dat = '0; cmd_sel = 4'hF;
            tick();
        end
        cmd_adr = 32'h3000_0110;
        chk("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_stb", {31'd0, stb}, 32'd0);
            chk("t5_rsp_hold", rsp_dat, 32'h1234_5678);
            chk("t5_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("t3_still_full", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t5_rsp_taken", {31'd0, rsp_valid}, 32'd0);
        cnt = 0;
        while (cmd_ready !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("t3_fifth_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_stb();
            chk("t3_order_adr", adr, 32'h3000_0100 + 32'(4 * j));
            chk("t3_we", {31'd0, we}, 32'd0);
            tick(); tick();
            ack = 1'b1; rdat = 32'hD000_0000 + 32'(j);
            tick();
            ack = 1'b0; rdat = '0;
            chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_rsp_dat", rsp_dat, 32'hD000_0000 + 32'(j));
            chk("t3_rsp_err", {31'd0, rsp_err}, 32'd0);
        end
        tick();
        chk("t3_all_done", {31'd0, busy}, 32'd0);

        // 4: slave never acks
        push(1'b1, 32'h3800_0020, 32'h5555_AAAA, 4'hF);
        wait_stb();
        cnt = 0;
        while (stb === 1'b1 && cnt < 30) begin
            cnt++;
            tick();
        end
        chk("t4_stb_cycles", 32'(cnt), 32'd8);
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("t4_rsp_dat", rsp_dat, 32'h0);
        push(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        wait_stb();
        chk("t4_next_adr", adr, 32'h3000_0010);
        ack = 1'b1; rdat = 32'h1111_2222;
        tick();
        ack = 1'b0; rdat = '0;
        chk("t4_next_err", {31'd0, rsp_err}, 32'd0);
        chk("t4_next_dat", rsp_dat, 32'h1111_2222);
        tick();

        // 5b: ack arrives on the watchdog's last cycle
        push(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        wait_stb();
        repeat (7) tick();
        chk("t5b_stb_last", {31'd0, stb}, 32'd1);
        ack = 1'b1; rdat = 32'h7777_8888;
        tick();
        ack = 1'b0; rdat = '0;
        chk("t5b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t5b_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("t5b_rsp_dat", rsp_dat, 32'h7777_8888);
        tick();

        // 6: reset in the middle of a bus cycle with a queued command
        push(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        wait_stb();
        push(1'b1, 32'h3800_0030, 32'h1, 4'h1);
        chk("t6_stb_before", {31'd0, stb}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc_async", {31'd0, cyc}, 32'd0);
        chk("t6_stb_async", {31'd0, stb}, 32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t6_post_busy", {31'd0, busy}, 32'd0);
        chk("t6_post_stb", {31'd0, stb}, 32'd0);
        chk("t6_post_ready", {31'd0, cmd_ready}, 32'd1);
        push(1'b1, 32'h3800_0040, 32'h0BAD_F00D, 4'h3);
        wait_stb();
        chk("t6_rec_adr", adr, 32'h3800_0040);
        chk("t6_rec_sel", {28'd0, sel}, 32'h3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t6_rec_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("t6_rec_err", {31'd0, rsp_err}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
